// File: rtl/rbus_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rbus_axi_pkg
// Description : Shared AXI4 types, ID constants and the size-encoding helper
//               used by the rbus MIF to AXI bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package rbus_axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam int AXI_ID_WR = 0;
    localparam int AXI_ID_RD = 1;

    // AxSIZE encoding: log2 of the number of bytes per beat (1..128 bytes)
    function automatic logic [2:0] axi_size(input int bytes);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                s = 3'(i);
            end
        end
        return s;
    endfunction

endpackage : rbus_axi_pkg
`default_nettype wire

// File: rtl/rbus_axi_addr_slot.sv
`default_nettype none
// ============================================================================
// Module      : rbus_axi_addr_slot
// Description : Single-entry valid/hold register for an AXI address channel.
//               Loads an address, raises valid on the following cycle and
//               holds address and valid stable until the slave takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module rbus_axi_addr_slot #(
    parameter int ADDR_W = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    // Load has priority; the caller only loads while the slot is empty
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (i_load) begin
            valid_d = 1'b1;
            addr_d  = i_addr;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;

endmodule : rbus_axi_addr_slot
`default_nettype wire

// File: rtl/rbus_mif_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : rbus_mif_axi_bridge
// Description : Bridge from an rbus MIF command/data port to an AXI4 master.
//               Registered AW/AR slots, bounded outstanding counters,
//               bridge-generated wlast and write-data gating.
//               Optional response checking: RBUS_MIF_AXI_RESP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rbus_mif_axi_bridge
    import rbus_axi_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 29,
    parameter int BURST_BEATS = 4,
    parameter int MAX_OUTST   = 4,
    parameter int ID_W        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    // command side
    input  logic                             co_wr_stb,
    input  logic                             co_rd_stb,
    input  logic [ADDR_W-1:0]                co_addr,
    output logic                             co_wr_rdy,
    output logic                             co_rd_rdy,
    // write data side
    input  logic                             do_stb,
    input  logic [DATA_W-1:0]                do_data,
    input  logic [DATA_W/8-1:0]              do_mask,
    output logic                             do_rdy,
    // responses
    output logic                             ci_wr_end,
    output logic                             di_en,
    output logic                             di_end,
    output logic [DATA_W-1:0]                di_data,
    // AXI write address
    output logic [ADDR_W-1:0]                M_AXI_awaddr,
    output logic [7:0]                       M_AXI_awlen,
    output logic [2:0]                       M_AXI_awsize,
    output logic [1:0]                       M_AXI_awburst,
    output logic [ID_W-1:0]                  M_AXI_awid,
    output logic                             M_AXI_awvalid,
    input  logic                             M_AXI_awready,
    output logic [3:0]                       M_AXI_awcache,
    output logic                             M_AXI_awlock,
    output logic [2:0]                       M_AXI_awprot,
    output logic [3:0]                       M_AXI_awqos,
    output logic [3:0]                       M_AXI_awregion,
    // AXI write data / response
    output logic [DATA_W-1:0]                M_AXI_wdata,
    output logic [DATA_W/8-1:0]              M_AXI_wstrb,
    output logic                             M_AXI_wlast,
    output logic                             M_AXI_wvalid,
    input  logic                             M_AXI_wready,
    input  logic [ID_W-1:0]                  M_AXI_bid,
    input  logic [1:0]                       M_AXI_bresp,
    input  logic                             M_AXI_bvalid,
    output logic                             M_AXI_bready,
    // AXI read address
    output logic [ADDR_W-1:0]                M_AXI_araddr,
    output logic [7:0]                       M_AXI_arlen,
    output logic [2:0]                       M_AXI_arsize,
    output logic [1:0]                       M_AXI_arburst,
    output logic [ID_W-1:0]                  M_AXI_arid,
    output logic                             M_AXI_arvalid,
    input  logic                             M_AXI_arready,
    output logic [3:0]                       M_AXI_arcache,
    output logic                             M_AXI_arlock,
    output logic [2:0]                       M_AXI_arprot,
    output logic [3:0]                       M_AXI_arqos,
    output logic [3:0]                       M_AXI_arregion,
    // AXI read data
    input  logic [DATA_W-1:0]                M_AXI_rdata,
    input  logic [ID_W-1:0]                  M_AXI_rid,
    input  logic [1:0]                       M_AXI_rresp,
    input  logic                             M_AXI_rlast,
    input  logic                             M_AXI_rvalid,
    output logic                             M_AXI_rready,
    // status
    output logic [2:0]                       err,
    output logic [$clog2(MAX_OUTST+1)-1:0]   wr_outst,
    output logic [$clog2(MAX_OUTST+1)-1:0]   rd_outst
);

    localparam int               CNT_W     = $clog2(MAX_OUTST + 1);
    localparam int               BEAT_W    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [CNT_W-1:0]  OUTST_MAX = CNT_W'(MAX_OUTST);
    localparam logic [7:0]        AXLEN     = 8'(BURST_BEATS - 1);
    localparam logic [2:0]        AXSIZE    = axi_size(DATA_W / 8);

    logic              w_wr_acc, w_rd_acc;
    logic              w_aw_valid, w_ar_valid;
    logic              w_wr_dec, w_rd_dec;
    logic              w_w_hs, w_w_done;
    logic [CNT_W-1:0]  wr_outst_q, wr_outst_d;
    logic [CNT_W-1:0]  rd_outst_q, rd_outst_d;
    logic [CNT_W-1:0]  wpend_q, wpend_d;
    logic [BEAT_W-1:0] wbeat_q, wbeat_d;

    // ---------------- command acceptance ----------------
    assign co_wr_rdy = !w_aw_valid && (wr_outst_q < OUTST_MAX);
    assign co_rd_rdy = !w_ar_valid && (rd_outst_q < OUTST_MAX) && !co_wr_stb;
    assign w_wr_acc  = co_wr_stb && co_wr_rdy;
    assign w_rd_acc  = co_rd_stb && co_rd_rdy;

    rbus_axi_addr_slot #(.ADDR_W(ADDR_W)) u_aw_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_wr_acc),
        .i_addr  (co_addr),
        .i_ready (M_AXI_awready),
        .o_valid (w_aw_valid),
        .o_addr  (M_AXI_awaddr)
    );

    rbus_axi_addr_slot #(.ADDR_W(ADDR_W)) u_ar_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rd_acc),
        .i_addr  (co_addr),
        .i_ready (M_AXI_arready),
        .o_valid (w_ar_valid),
        .o_addr  (M_AXI_araddr)
    );

    // ---------------- constant AXI fields ----------------
    assign M_AXI_awvalid  = w_aw_valid;
    assign M_AXI_awlen    = AXLEN;
    assign M_AXI_awsize   = AXSIZE;
    assign M_AXI_awburst  = AXI_BURST_INCR;
    assign M_AXI_awid     = ID_W'(AXI_ID_WR);
    assign M_AXI_awcache  = 4'd0;
    assign M_AXI_awlock   = 1'b0;
    assign M_AXI_awprot   = 3'd0;
    assign M_AXI_awqos    = 4'd0;
    assign M_AXI_awregion = 4'd0;

    assign M_AXI_arvalid  = w_ar_valid;
    assign M_AXI_arlen    = AXLEN;
    assign M_AXI_arsize   = AXSIZE;
    assign M_AXI_arburst  = AXI_BURST_INCR;
    assign M_AXI_arid     = ID_W'(AXI_ID_RD);
    assign M_AXI_arcache  = 4'd0;
    assign M_AXI_arlock   = 1'b0;
    assign M_AXI_arprot   = 3'd0;
    assign M_AXI_arqos    = 4'd0;
    assign M_AXI_arregion = 4'd0;

    // ---------------- write data path ----------------
    // Data only flows once a write command has been accepted for it
    assign M_AXI_wvalid = do_stb && (wpend_q != '0);
    assign do_rdy       = M_AXI_wready && (wpend_q != '0);
    assign M_AXI_wdata  = do_data;
    assign M_AXI_wstrb  = ~do_mask;
    assign M_AXI_wlast  = (wbeat_q == LAST_BEAT);
    assign w_w_hs       = M_AXI_wvalid && M_AXI_wready;
    assign w_w_done     = w_w_hs && M_AXI_wlast;

    // ---------------- read / response pass-through ----------------
    assign M_AXI_bready = 1'b1;
    assign M_AXI_rready = 1'b1;
    assign ci_wr_end    = M_AXI_bvalid;
    assign di_en        = M_AXI_rvalid;
    assign di_end       = M_AXI_rlast;
    assign di_data      = M_AXI_rdata;

    // Decrements are ignored at zero so a stray response cannot underflow
    assign w_wr_dec = M_AXI_bvalid && (wr_outst_q != '0);
    assign w_rd_dec = M_AXI_rvalid && M_AXI_rlast && (rd_outst_q != '0);

    // Next-state for outstanding counters, pending bursts and beat counter
    always_comb begin
        wr_outst_d = wr_outst_q;
        rd_outst_d = rd_outst_q;
        wpend_d    = wpend_q;
        wbeat_d    = wbeat_q;
        if (w_wr_acc && !w_wr_dec) begin
            wr_outst_d = wr_outst_q + CNT_W'(1);
        end else if (!w_wr_acc && w_wr_dec) begin
            wr_outst_d = wr_outst_q - CNT_W'(1);
        end
        if (w_rd_acc && !w_rd_dec) begin
            rd_outst_d = rd_outst_q + CNT_W'(1);
        end else if (!w_rd_acc && w_rd_dec) begin
            rd_outst_d = rd_outst_q - CNT_W'(1);
        end
        if (w_wr_acc && !w_w_done) begin
            wpend_d = wpend_q + CNT_W'(1);
        end else if (!w_wr_acc && w_w_done) begin
            wpend_d = wpend_q - CNT_W'(1);
        end
        if (w_w_hs) begin
            wbeat_d = M_AXI_wlast ? '0 : wbeat_q + BEAT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_outst_q <= '0;
            rd_outst_q <= '0;
            wpend_q    <= '0;
            wbeat_q    <= '0;
        end else begin
            wr_outst_q <= wr_outst_d;
            rd_outst_q <= rd_outst_d;
            wpend_q    <= wpend_d;
            wbeat_q    <= wbeat_d;
        end
    end

    assign wr_outst = wr_outst_q;
    assign rd_outst = rd_outst_q;

`ifdef RBUS_MIF_AXI_RESP_CHECK_EN
    logic [BEAT_W-1:0] rbeat_q, rbeat_d;
    logic [2:0]        err_q, err_d;

    // Track read beats; rlast re-aligns the counter so one bad burst
    // does not poison the following ones. Flags are sticky until reset.
    always_comb begin
        rbeat_d = rbeat_q;
        err_d   = err_q;
        if (M_AXI_rvalid) begin
            rbeat_d = (M_AXI_rlast || (rbeat_q == LAST_BEAT)) ? '0 : rbeat_q + BEAT_W'(1);
            if (M_AXI_rlast != (rbeat_q == LAST_BEAT)) begin
                err_d[2] = 1'b1;
            end
            if (M_AXI_rresp != AXI_RESP_OKAY) begin
                err_d[1] = 1'b1;
            end
        end
        if (M_AXI_bvalid && (M_AXI_bresp != AXI_RESP_OKAY)) begin
            err_d[0] = 1'b1;
        end
    end

    // Checker registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rbeat_q <= '0;
            err_q   <= 3'b000;
        end else begin
            rbeat_q <= rbeat_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 3'b000;
`endif

    // IDs and (without checking) response codes are intentionally not consumed
    logic w_unused;
    assign w_unused = ^{M_AXI_bid, M_AXI_rid, M_AXI_bresp, M_AXI_rresp};

endmodule : rbus_mif_axi_bridge
`default_nettype wire
